// File: rtl/scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scanner_pkg
// Description : Shared types and constants for the scanner serial transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package scanner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam int FRAME_BITS         = 7;
    localparam int DATA_BITS          = 4;
    localparam int DEFAULT_BIT_CYCLES = 4;

    // Odd parity: the frame's five data+parity bits always hold an odd number of ones.
    function automatic logic odd_parity(input logic [DATA_BITS-1:0] bits);
        return ~(^bits);
    endfunction

endpackage : scanner_pkg
`default_nettype wire

// File: rtl/bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : bit_timer
// Description : Counts 0..BIT_CYCLES-1 while running; strobes bit_done on the
//               last cycle of every serial bit.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_timer
    import scanner_pkg::*;
#(
    parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic bit_done
);

    localparam logic [7:0] C_LAST = 8'(BIT_CYCLES - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Counter is parked at zero while idle so the first bit of a frame is full length.
    always_comb begin
        count_d  = '0;
        bit_done = 1'b0;
        if (run) begin
            if (count_q == C_LAST) begin
                bit_done = 1'b1;
            end else begin
                count_d = count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : bit_timer
`default_nettype wire

// File: rtl/scanner_tx.sv
`default_nettype none
// ============================================================================
// Module      : scanner_tx
// Description : Serialises a 4-bit item code as start / MUPC / odd parity /
//               stop, each bit held BIT_CYCLES clocks, idle-high line.
// Revision    : 1.0 - initial release
// ============================================================================
module scanner_tx
    import scanner_pkg::*;
#(
    parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] code,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic [7:0] sent_count
);

    state_t     state_q,      state_d;
    logic [3:0] code_q,       code_d;
    logic [3:0] shift_q,      shift_d;
    logic [1:0] bit_idx_q,    bit_idx_d;
    logic [7:0] sent_count_q, sent_count_d;
    logic       tx_q,         tx_d;
    logic       w_bit_done;

    bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .run      (state_q != ST_IDLE),
        .bit_done (w_bit_done)
    );

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        sent_count_d = sent_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (valid) begin
                    state_d = ST_START;
                    code_d  = code;
                    shift_d = code;
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    if (bit_idx_q == 2'(DATA_BITS - 1)) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + 2'd1;
                        shift_d   = {shift_q[2:0], 1'b0};
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_done) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit_done) begin
                    state_d      = ST_IDLE;
                    sent_count_d = sent_count_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // tx is decoded from the next state so the line itself comes straight off a flop.
        unique case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[3];
            ST_PARITY: tx_d = odd_parity(code_q);
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            code_q       <= '0;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            sent_count_q <= '0;
            tx_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            sent_count_q <= sent_count_d;
            tx_q         <= tx_d;
        end
    end

    assign ready      = (state_q == ST_IDLE);
    assign busy       = ~ready;
    assign tx         = tx_q;
    assign sent_count = sent_count_q;

endmodule : scanner_tx
`default_nettype wire

// File: tb/tb_scanner_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_scanner_tx
// Description : Scoreboard bench for scanner_tx (BIT_CYCLES=4 and =1 builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scanner_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] code0, code1;
    logic       valid0, valid1;
    logic       ready0, ready1, tx0, tx1, busy0, busy1;
    logic [7:0] cnt0, cnt1;

    always #5 clk = ~clk;

    scanner_tx #(.BIT_CYCLES(4)) dut0 (
        .clk(clk), .reset(reset), .code(code0), .valid(valid0),
        .ready(ready0), .tx(tx0), .busy(busy0), .sent_count(cnt0)
    );

    scanner_tx #(.BIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .code(code1), .valid(valid1),
        .ready(ready1), .tx(tx1), .busy(busy1), .sent_count(cnt1)
    );

    typedef struct {
        int         dut;
        logic [6:0] frame;
        logic [7:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    logic [7:0] exp_cnt [2];
    int         last_acc [2];
    bit         cap [2];
    bit         has_exp [2];
    bit         bad [2];
    int         idx [2];
    exp_t       cur [2];
    logic [6:0] got [2];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference frame: start(0), M U P C, odd parity, stop(1); used for the long sweep.
    function automatic logic [6:0] model_frame(input logic [3:0] c);
        return {1'b0, c, ~(^c), 1'b1};
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic send(input int d, input logic [3:0] c, input logic [6:0] frame,
                        input int gap, input bit hold);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        if (d == 0) begin code0 = c; valid0 = 1'b1; end
        else        begin code1 = c; valid1 = 1'b1; end
        while (((d == 0) ? ready0 : ready1) == 1'b0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout dut%0d: ready stayed 0, expected 1", d);
        end else begin
            exp_cnt[d] = exp_cnt[d] + 8'd1;
            e.dut   = d;
            e.frame = frame;
            e.cnt   = exp_cnt[d];
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            if (gap > 0) check($sformatf("accept_gap dut%0d", d), cyc - last_acc[d], gap);
            last_acc[d] = cyc;
        end
        if (!hold) begin
            if (d == 0) valid0 = 1'b0;
            else        valid1 = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || cap[0] || cap[1]) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        if (g >= 3000) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d frames pending, expected 0", exp_q.size());
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_cnt[0] = '0;
        exp_cnt[1] = '0;
    endtask

    initial begin
        reset  = 1'b1;
        code0  = 4'b0; code1  = 4'b0;
        valid0 = 1'b0; valid1 = 1'b0;
        exp_cnt[0] = '0; exp_cnt[1] = '0;
        for (int d = 0; d < 2; d++) begin
            cap[d] = 1'b0; has_exp[d] = 1'b0; bad[d] = 1'b0; idx[d] = 0; last_acc[d] = 0;
        end

        fork
            forever begin : monitor
                @(negedge clk);
                for (int d = 0; d < 2; d++) begin
                    logic t, b, r;
                    logic [7:0] c;
                    int bc, k;
                    t  = (d == 0) ? tx0    : tx1;
                    b  = (d == 0) ? busy0  : busy1;
                    r  = (d == 0) ? ready0 : ready1;
                    c  = (d == 0) ? cnt0   : cnt1;
                    bc = (d == 0) ? 4 : 1;
                    if (reset) begin
                        cap[d] = 1'b0;
                    end else begin
                        if (!cap[d] && b) begin
                            cap[d] = 1'b1; idx[d] = 0; bad[d] = 1'b0; got[d] = '0;
                            if (exp_q.size() > 0 && exp_q[0].dut == d) begin
                                cur[d]     = exp_q.pop_front();
                                has_exp[d] = 1'b1;
                            end else begin
                                has_exp[d] = 1'b0;
                                n_tests++;
                                n_fail++;
                                $display("FAIL unexpected_frame dut%0d: busy=1, expected idle", d);
                            end
                        end
                        if (cap[d]) begin
                            if (idx[d] < 7 * bc) begin
                                k = 6 - idx[d] / bc;
                                if (idx[d] % bc == 0) got[d][k] = t;
                                if (has_exp[d] && (b !== 1'b1 || r !== 1'b0 || t !== cur[d].frame[k]))
                                    bad[d] = 1'b1;
                                idx[d]++;
                            end else begin
                                cap[d] = 1'b0;
                                if (has_exp[d]) begin
                                    n_tests++;
                                    if (bad[d]) begin
                                        n_fail++;
                                        $display("FAIL frame dut%0d: tx bits %b, expected %b held %0d cycles each with busy=1",
                                                 d, got[d], cur[d].frame, bc);
                                    end
                                    check($sformatf("frame_end_busy dut%0d", d), int'(b), 0);
                                    check($sformatf("sent_count dut%0d", d), int'(c), int'(cur[d].cnt));
                                end
                            end
                        end
                    end
                end
            end
        join_none

        // Reset state, held across several edges.
        repeat (3) @(posedge clk);
        #1;
        check("reset tx",     int'(tx0),    1);
        check("reset ready",  int'(ready0), 1);
        check("reset busy",   int'(busy0),  0);
        check("reset count",  int'(cnt0),   0);
        check("reset tx dut1", int'(tx1),   1);
        @(negedge clk);
        reset = 1'b0;

        // Abort mid-DATA: line returns high at once, nothing counted.
        send(0, 4'b1111, 7'b0111111, 0, 0);
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort tx",    int'(tx0),    1);
        check("abort ready", int'(ready0), 1);
        check("abort count", int'(cnt0),   0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_cnt[0] = '0;
        exp_cnt[1] = '0;

        send(0, 4'b1010, 7'b0101011, 0, 0);
        wait_idle();
        send(0, 4'b0111, 7'b0011101, 0, 0);
        wait_idle();

        // Held valid; code changes while the first frame is still on the line.
        send(0, 4'b1100, 7'b0110011, 0, 1);
        send(0, 4'b0011, 7'b0001111, 29, 0);
        wait_idle();

        pulse_reset();
        for (int i = 0; i < 256; i++) begin
            send(0, 4'(i), model_frame(4'(i)), (i == 0) ? 0 : 29, i != 255);
        end
        wait_idle();
        check("count after 256 frames", int'(cnt0), 0);

        send(1, 4'b0000, 7'b0000011, 0, 1);
        send(1, 4'b1001, 7'b0100111, 8, 0);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_scanner_tx
`default_nettype wire
